// File: rtl/rs_issue_reg.sv
// Issue-stage register bank behind the two-way RS selector. Steers up to two granted RS
// entries per cycle into ALU0/ALU1/MULT/MEM holding registers. func_sel per slot: 0=NOP 1=ALU 2=MULT 3=MEM.

module rs_issue_slot #(
    parameter int WIDTH  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic [WIDTH-1:0]        gnt,
    input  logic [1:0]              func,
    input  logic [WIDTH*DATA_W-1:0] rs_opa,
    input  logic [WIDTH*DATA_W-1:0] rs_opb,
    input  logic [WIDTH*TAG_W-1:0]  rs_dest_tag,
    output logic                    is_alu,
    output logic                    is_mult,
    output logic                    is_mem,
    output logic                    bad_gnt,
    output logic [DATA_W-1:0]       opa,
    output logic [DATA_W-1:0]       opb,
    output logic [TAG_W-1:0]        tag
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IDX_W-1:0] idx;
    logic             live;

    // Lowest set bit wins, so a malformed grant still yields a deterministic index.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (gnt[i]) idx = IDX_W'(i);
    end

    assign live    = (|gnt) && (func != 2'd0);
    assign is_alu  = live && (func == 2'd1);
    assign is_mult = live && (func == 2'd2);
    assign is_mem  = live && (func == 2'd3);
    assign bad_gnt = |(gnt & (gnt - WIDTH'(1)));

    assign opa = rs_opa[int'(idx)*DATA_W +: DATA_W];
    assign opb = rs_opb[int'(idx)*DATA_W +: DATA_W];
    assign tag = rs_dest_tag[int'(idx)*TAG_W +: TAG_W];
endmodule

module rs_issue_reg #(
    parameter int WIDTH  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [2*WIDTH-1:0]      gnt_bus,
    input  logic [3:0]              func_sel,
    input  logic [WIDTH*DATA_W-1:0] rs_opa,
    input  logic [WIDTH*DATA_W-1:0] rs_opb,
    input  logic [WIDTH*TAG_W-1:0]  rs_dest_tag,
    input  logic                    squash,
    input  logic                    alu0_ready,
    input  logic                    alu1_ready,
    output logic                    alu0_stall_out,
    output logic                    alu1_stall_out,
    output logic                    alu0_valid,
    output logic [DATA_W-1:0]       alu0_opa,
    output logic [DATA_W-1:0]       alu0_opb,
    output logic [TAG_W-1:0]        alu0_tag,
    output logic                    alu1_valid,
    output logic [DATA_W-1:0]       alu1_opa,
    output logic [DATA_W-1:0]       alu1_opb,
    output logic [TAG_W-1:0]        alu1_tag,
    output logic                    mult_valid,
    output logic [DATA_W-1:0]       mult_opa,
    output logic [DATA_W-1:0]       mult_opb,
    output logic [TAG_W-1:0]        mult_tag,
    output logic                    mem_valid,
    output logic [DATA_W-1:0]       mem_opa,
    output logic [DATA_W-1:0]       mem_opb,
    output logic [TAG_W-1:0]        mem_tag,
    output logic [31:0]             issue_cnt,
    output logic                    illegal_issue
);
    logic [1:0]             slot_alu, slot_mult, slot_mem, slot_bad;
    logic [1:0][DATA_W-1:0] slot_opa, slot_opb;
    logic [1:0][TAG_W-1:0]  slot_tag;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        rs_issue_slot #(.WIDTH(WIDTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_slot (
            .gnt         (gnt_bus[s*WIDTH +: WIDTH]),
            .func        (func_sel[2*s +: 2]),
            .rs_opa      (rs_opa),
            .rs_opb      (rs_opb),
            .rs_dest_tag (rs_dest_tag),
            .is_alu      (slot_alu[s]),
            .is_mult     (slot_mult[s]),
            .is_mem      (slot_mem[s]),
            .bad_gnt     (slot_bad[s]),
            .opa         (slot_opa[s]),
            .opb         (slot_opb[s]),
            .tag         (slot_tag[s])
        );
    end

    logic       alu0_free, alu1_free;
    logic [1:0] free_alu;

    assign alu0_free      = !alu0_valid || alu0_ready;
    assign alu1_free      = !alu1_valid || alu1_ready;
    assign free_alu       = 2'(alu0_free) + 2'(alu1_free);
    assign alu1_stall_out = (free_alu < 2'd2);
    assign alu0_stall_out = (free_alu == 2'd0);

    logic ld_alu0, ld_alu1, src_alu0, src_alu1, drop_alu;

    // Slot0 claims first; each slot takes the lowest free ALU not already claimed.
    always_comb begin
        ld_alu0  = 1'b0;
        ld_alu1  = 1'b0;
        src_alu0 = 1'b0;
        src_alu1 = 1'b0;
        drop_alu = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (slot_alu[s]) begin
                if (alu0_free && !ld_alu0) begin
                    ld_alu0  = 1'b1;
                    src_alu0 = 1'(s);
                end else if (alu1_free && !ld_alu1) begin
                    ld_alu1  = 1'b1;
                    src_alu1 = 1'(s);
                end else begin
                    drop_alu = 1'b1;
                end
            end
        end
    end

    logic       ld_mult, ld_mem, src_mult, src_mem, proto_err;
    logic [1:0] n_load;

    assign ld_mult   = |slot_mult;
    assign ld_mem    = |slot_mem;
    assign src_mult  = !slot_mult[0];
    assign src_mem   = !slot_mem[0];
    assign n_load    = 2'(ld_alu0) + 2'(ld_alu1) + 2'(ld_mult) + 2'(ld_mem);
    assign proto_err = (|slot_bad) || drop_alu || (&slot_mult) || (&slot_mem);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu0_valid <= 1'b0; alu0_opa <= '0; alu0_opb <= '0; alu0_tag <= '0;
            alu1_valid <= 1'b0; alu1_opa <= '0; alu1_opb <= '0; alu1_tag <= '0;
            mult_valid <= 1'b0; mult_opa <= '0; mult_opb <= '0; mult_tag <= '0;
            mem_valid  <= 1'b0; mem_opa  <= '0; mem_opb  <= '0; mem_tag  <= '0;
            issue_cnt     <= '0;
            illegal_issue <= 1'b0;
        end else begin
            illegal_issue <= illegal_issue | proto_err;
            if (squash) begin
                alu0_valid <= 1'b0;
                alu1_valid <= 1'b0;
                mult_valid <= 1'b0;
                mem_valid  <= 1'b0;
            end else begin
                if (ld_alu0) begin
                    alu0_valid <= 1'b1;
                    alu0_opa   <= slot_opa[src_alu0];
                    alu0_opb   <= slot_opb[src_alu0];
                    alu0_tag   <= slot_tag[src_alu0];
                end else if (alu0_ready) begin
                    alu0_valid <= 1'b0;
                end
                if (ld_alu1) begin
                    alu1_valid <= 1'b1;
                    alu1_opa   <= slot_opa[src_alu1];
                    alu1_opb   <= slot_opb[src_alu1];
                    alu1_tag   <= slot_tag[src_alu1];
                end else if (alu1_ready) begin
                    alu1_valid <= 1'b0;
                end
                mult_valid <= ld_mult;
                if (ld_mult) begin
                    mult_opa <= slot_opa[src_mult];
                    mult_opb <= slot_opb[src_mult];
                    mult_tag <= slot_tag[src_mult];
                end
                mem_valid <= ld_mem;
                if (ld_mem) begin
                    mem_opa <= slot_opa[src_mem];
                    mem_opb <= slot_opb[src_mem];
                    mem_tag <= slot_tag[src_mem];
                end
                issue_cnt <= issue_cnt + 32'(n_load);
            end
        end
    end
endmodule
